// File: rtl/uart_tx_scheduler_if.sv
// Request bus shared by the byte sources feeding uart_tx_scheduler.
// Requester i offers REQ_DATA[8i+7:8i] while REQ_VALID[i] is high until REQ_READY[i].
`default_nettype none

interface uart_tx_scheduler_if #(
   parameter int REQ_COUNT = 3
);
   logic [REQ_COUNT-1:0]   REQ_VALID;
   logic [8*REQ_COUNT-1:0] REQ_DATA;
   logic [REQ_COUNT-1:0]   REQ_READY;

   modport master (
      output REQ_VALID,
      output REQ_DATA,
      input  REQ_READY
   );

   modport slave (
      input  REQ_VALID,
      input  REQ_DATA,
      output REQ_READY
   );
endinterface

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter in front of an 8N1 UART transmitter with its own baud timing.
// One byte is accepted per idle cycle; the winner's byte is sent LSB first on TXD.
`default_nettype none

module uart_tx_scheduler #(
   parameter int CLOCKS_PER_BAUD = 5208,
   parameter int REQ_COUNT       = 3,
   parameter int ID_WIDTH        = 2
) (
   input  logic                CLOCK_50M,
   input  logic                RESET_N,
   uart_tx_scheduler_if.slave  req,
   output logic                TXD,
   output logic                BUSY,
   output logic [ID_WIDTH-1:0] GRANT_ID,
   output logic                TX_DONE
);

   localparam int              CNT_W   = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
   localparam logic [CNT_W-1:0] BIT_END = CNT_W'(CLOCKS_PER_BAUD - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [1:0]          state;
   logic [1:0]          state_nxt;
   logic [CNT_W-1:0]    baud_cnt;
   logic [CNT_W-1:0]    baud_cnt_nxt;
   logic [2:0]          bit_idx;
   logic [2:0]          bit_idx_nxt;
   logic [7:0]          shift;
   logic [7:0]          shift_nxt;
   logic [ID_WIDTH-1:0] last_grant;
   logic [ID_WIDTH-1:0] last_grant_nxt;
   logic [ID_WIDTH-1:0] grant_nxt;
   logic                txd_nxt;
   logic                busy_nxt;
   logic                done_nxt;

   logic                bit_end;
   logic                accept;
   logic                win_found;
   logic [ID_WIDTH-1:0] win_idx;
   logic [REQ_COUNT-1:0] win_onehot;
   logic [7:0]          win_data;

   assign bit_end = (baud_cnt == BIT_END);

   // Search order starts just after the last grant; first valid requester found wins.
   always_comb begin
      win_found  = 1'b0;
      win_idx    = '0;
      win_onehot = '0;
      win_data   = '0;
      for (int k = 1; k <= REQ_COUNT; k++) begin
         for (int i = 0; i < REQ_COUNT; i++) begin
            if (!win_found && req.REQ_VALID[i] &&
                (i == ((int'(last_grant) + k) % REQ_COUNT))) begin
               win_found     = 1'b1;
               win_idx       = ID_WIDTH'(i);
               win_onehot[i] = 1'b1;
               win_data      = req.REQ_DATA[8*i +: 8];
            end
         end
      end
   end

   // Gated by RESET_N so no byte is taken while reset is held.
   assign accept        = (state == S_IDLE) && win_found && RESET_N;
   assign req.REQ_READY = accept ? win_onehot : '0;

   always_ff @(posedge CLOCK_50M or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept)                     state_nxt = S_START;
         S_START: if (bit_end)                    state_nxt = S_DATA;
         S_DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = S_STOP;
         S_STOP:  if (bit_end)                    state_nxt = S_IDLE;
         default:                                 state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      baud_cnt_nxt   = bit_end ? '0 : baud_cnt + 1'b1;
      bit_idx_nxt    = bit_idx;
      shift_nxt      = shift;
      last_grant_nxt = last_grant;
      grant_nxt      = GRANT_ID;
      done_nxt       = 1'b0;
      case (state)
         S_IDLE: begin
            baud_cnt_nxt = '0;
            if (accept) begin
               shift_nxt      = win_data;
               grant_nxt      = win_idx;
               last_grant_nxt = win_idx;
               bit_idx_nxt    = 3'd0;
            end
         end
         S_START: begin
            if (bit_end) bit_idx_nxt = 3'd0;
         end
         S_DATA: begin
            if (bit_end) begin
               shift_nxt   = shift >> 1;
               bit_idx_nxt = bit_idx + 3'd1;
            end
         end
         S_STOP: begin
            if (bit_end) done_nxt = 1'b1;
         end
         default: begin
            baud_cnt_nxt = '0;
         end
      endcase

      // TXD is registered, so it is derived from the state being entered.
      busy_nxt = (state_nxt != S_IDLE);
      case (state_nxt)
         S_START: txd_nxt = 1'b0;
         S_DATA:  txd_nxt = shift_nxt[0];
         default: txd_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge CLOCK_50M or negedge RESET_N) begin
      if (!RESET_N) begin
         baud_cnt   <= '0;
         bit_idx    <= 3'd0;
         shift      <= 8'd0;
         last_grant <= ID_WIDTH'(REQ_COUNT - 1);
         GRANT_ID   <= '0;
         TXD        <= 1'b1;
         BUSY       <= 1'b0;
         TX_DONE    <= 1'b0;
      end else begin
         baud_cnt   <= baud_cnt_nxt;
         bit_idx    <= bit_idx_nxt;
         shift      <= shift_nxt;
         last_grant <= last_grant_nxt;
         GRANT_ID   <= grant_nxt;
         TXD        <= txd_nxt;
         BUSY       <= busy_nxt;
         TX_DONE    <= done_nxt;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: a fast-baud instance for protocol and
// arbitration cases, and a default-parameter instance for exact bit timing.
`default_nettype none

module tb_uart_tx_scheduler;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int     checks   = 0;
   int     failures = 0;
   longint cyc      = 0;
   longint acc_cyc  = 0;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_scheduler_if #(.REQ_COUNT(3)) rq  ();
   uart_tx_scheduler_if #(.REQ_COUNT(3)) rq6 ();

   logic       txd, busy, tx_done;
   logic [1:0] grant_id;
   logic       txd6, busy6, tx_done6;
   logic [1:0] grant_id6;

   uart_tx_scheduler #(.CLOCKS_PER_BAUD(4), .REQ_COUNT(3), .ID_WIDTH(2)) dut (
      .CLOCK_50M (clk),
      .RESET_N   (rst_n),
      .req       (rq),
      .TXD       (txd),
      .BUSY      (busy),
      .GRANT_ID  (grant_id),
      .TX_DONE   (tx_done)
   );

   uart_tx_scheduler dut6 (
      .CLOCK_50M (clk),
      .RESET_N   (rst_n),
      .req       (rq6),
      .TXD       (txd6),
      .BUSY      (busy6),
      .GRANT_ID  (grant_id6),
      .TX_DONE   (tx_done6)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Per-cycle TXD for one frame at 4 clocks/bit: start, 8 data bits LSB first, stop.
   function automatic logic [39:0] frame_model(input logic [7:0] b);
      logic [9:0]  f;
      logic [39:0] r;
      f = {1'b1, b, 1'b0};
      for (int i = 0; i < 40; i++) r[i] = f[i/4];
      return r;
   endfunction

   // Called at a negedge; checks READY for the expected winner and steps past the accept edge.
   task automatic accept(input int idx, input string tag);
      int n;
      n = 0;
      #1;
      while (rq.REQ_READY == 3'b000 && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      check({tag, "_ready"}, 64'(rq.REQ_READY), 64'(1) << idx);
      acc_cyc = cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input logic [7:0] b, input int id, input string tag);
      logic [39:0] obs;
      int          bcnt, dcnt;
      bcnt = 0;
      dcnt = 0;
      obs  = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         obs[i] = txd;
         bcnt  += int'(busy);
         dcnt  += int'(tx_done);
         if (i == 0) check({tag, "_grant"}, 64'(grant_id), 64'(id));
      end
      check({tag, "_bits"},     64'(obs),  64'(frame_model(b)));
      check({tag, "_busy_len"}, 64'(bcnt), 64'd40);
      check({tag, "_done_mid"}, 64'(dcnt), 64'd0);
      @(negedge clk);
      check({tag, "_done"},      64'(tx_done), 64'd1);
      check({tag, "_busy_idle"}, 64'(busy),    64'd0);
      check({tag, "_txd_idle"},  64'(txd),     64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] bytes [3];
      int         order [5];
      longint     prev_acc;
      logic [39:0] obs;
      int         rdy_cnt, low_cnt, busy_cnt, done_cnt;
      int         run, trans, bcount, n;
      logic       prev;

      bytes = '{8'hA1, 8'hB2, 8'hC3};
      order = '{0, 1, 2, 0, 1};

      rq.REQ_VALID  = 3'b111;
      rq.REQ_DATA   = '0;
      rq6.REQ_VALID = 3'b000;
      rq6.REQ_DATA  = '0;

      // Reset state, with all requesters valid to show READY held low.
      repeat (3) @(negedge clk);
      check("rst_txd",   64'(txd),          64'd1);
      check("rst_busy",  64'(busy),         64'd0);
      check("rst_done",  64'(tx_done),      64'd0);
      check("rst_grant", 64'(grant_id),     64'd0);
      check("rst_ready", 64'(rq.REQ_READY), 64'd0);
      rq.REQ_VALID = 3'b000;
      rst_n = 1'b1;

      // Test 1: single byte 0x42 from requester 0.
      @(negedge clk);
      rq.REQ_VALID = 3'b001;
      rq.REQ_DATA  = {8'h00, 8'h00, 8'h42};
      accept(0, "t1");
      rq.REQ_VALID = 3'b000;
      frame(8'h42, 0, "t1");
      @(negedge clk);
      check("t1_done_once", 64'(tx_done), 64'd0);
      check("t1_busy_after", 64'(busy), 64'd0);

      // Test 2: all valid from reset, order 0,1,2,0,1 and 41-cycle spacing.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      rq.REQ_VALID = 3'b111;
      rq.REQ_DATA  = {8'hC3, 8'hB2, 8'hA1};
      prev_acc = 0;
      for (int f = 0; f < 5; f++) begin
         accept(order[f], $sformatf("t2_f%0d", f));
         if (f > 0) check($sformatf("t2_gap%0d", f), 64'(acc_cyc - prev_acc), 64'd41);
         prev_acc = acc_cyc;
         // Test 3 setup: after the grant to 1, only requesters 0 and 1 remain valid.
         if (f == 4) rq.REQ_VALID = 3'b011;
         frame(bytes[order[f]], order[f], $sformatf("t2_f%0d", f));
      end

      // Test 3: fairness, 0 then 1.
      accept(0, "t3_a");
      frame(8'hA1, 0, "t3_a");
      accept(1, "t3_b");
      rq.REQ_VALID = 3'b000;
      frame(8'hB2, 1, "t3_b");

      // Test 4: requester 2 valid only mid-frame never sees READY.
      rq.REQ_VALID = 3'b001;
      rq.REQ_DATA  = {8'hEE, 8'hB2, 8'h5A};
      accept(0, "t4");
      rq.REQ_VALID = 3'b000;
      rdy_cnt = 0;
      obs     = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 8)  rq.REQ_VALID = 3'b100;
         if (i == 30) rq.REQ_VALID = 3'b000;
         obs[i] = txd;
         if (rq.REQ_READY != 3'b000) rdy_cnt++;
      end
      check("t4_bits",  64'(obs),     64'(frame_model(8'h5A)));
      check("t4_ready", 64'(rdy_cnt), 64'd0);
      low_cnt  = 0;
      busy_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (!txd) low_cnt++;
         if (busy) busy_cnt++;
         if (rq.REQ_READY != 3'b000) rdy_cnt++;
      end
      check("t4_idle_low",   64'(low_cnt),  64'd0);
      check("t4_idle_busy",  64'(busy_cnt), 64'd0);
      check("t4_idle_ready", 64'(rdy_cnt),  64'd0);

      // Test 5: reset during data bit 3 of 0x3C, requester 1 pending.
      rq.REQ_VALID = 3'b001;
      rq.REQ_DATA  = {8'h00, 8'h99, 8'h3C};
      accept(0, "t5");
      rq.REQ_VALID = 3'b000;
      repeat (17) @(negedge clk);
      check("t5_bit3", 64'(txd),  64'd1);
      check("t5_busy", 64'(busy), 64'd1);
      rq.REQ_VALID = 3'b010;
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_rst_txd",   64'(txd),          64'd1);
      check("t5_rst_busy",  64'(busy),         64'd0);
      check("t5_rst_ready", 64'(rq.REQ_READY), 64'd0);
      done_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         done_cnt += int'(tx_done);
      end
      check("t5_rst_done", 64'(done_cnt), 64'd0);
      rst_n = 1'b1;
      accept(1, "t5_post");
      rq.REQ_VALID = 3'b000;
      frame(8'h99, 1, "t5_post");

      // Test 6: default parameters, 0x55 gives a level change at every bit boundary.
      @(negedge clk);
      rq6.REQ_VALID = 3'b001;
      rq6.REQ_DATA  = {8'h00, 8'h00, 8'h55};
      #1;
      check("t6_ready", 64'(rq6.REQ_READY), 64'd1);
      @(posedge clk);
      #1;
      rq6.REQ_VALID = 3'b000;
      run    = 0;
      trans  = 0;
      bcount = 0;
      n      = 0;
      prev   = 1'b0;
      while (n < 60000) begin
         @(negedge clk);
         n++;
         if (!busy6) break;
         bcount++;
         if (txd6 === prev) begin
            run++;
         end else begin
            check($sformatf("t6_bit%0d_len", trans), 64'(run), 64'd5208);
            trans++;
            prev = txd6;
            run  = 1;
         end
      end
      check("t6_stop_len",  64'(run),      64'd5208);
      check("t6_trans",     64'(trans),    64'd9);
      check("t6_frame_len", 64'(bcount),   64'd52080);
      check("t6_done",      64'(tx_done6), 64'd1);
      check("t6_txd_idle",  64'(txd6),     64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
